tt_um_serial_add_ctrl: RTL

TT_UM_SERIAL_ADD_CTRL -- requirements
Module: tt_um_serial_add_ctrl

---
 rtl/tt_um_serial_add_ctrl_pkg.sv | 26 ++
 rtl/tt_um_serial_add_ctrl_fa_cell.sv | 20 ++
 rtl/tt_um_serial_add_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tt_um_serial_add_ctrl_pkg.sv
// Shared constants and types for the bit-serial adder tile: data width,
// controller states and the bidirectional-pin bit map.
package tt_um_serial_add_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // uio_in control bits
  localparam int UIO_LOAD_A = 0;
  localparam int UIO_LOAD_B = 1;
  localparam int UIO_START  = 2;

  // uio_out status bits
  localparam int UIO_BUSY     = 3;
  localparam int UIO_DONE     = 4;
  localparam int UIO_CARRY    = 5;
  localparam int UIO_OVERFLOW = 6;

  localparam logic [7:0] UIO_OE_VAL = 8'b0111_1000;

endpackage

// File: rtl/tt_um_serial_add_ctrl_fa_cell.sv
// One-bit full adder assembled from two half adders and an OR on the carries.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum_s;
  logic ha0_carry_s;
  logic ha1_carry_s;

  assign ha0_sum_s   = a ^ b;
  assign ha0_carry_s = a & b;
  assign sum         = ha0_sum_s ^ cin;
  assign ha1_carry_s = ha0_sum_s & cin;
  assign cout        = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/tt_um_serial_add_ctrl.sv
// Bit-serial A+B controller: operands are loaded in IDLE, a start edge runs
// WIDTH cycles through a single full-adder cell, and DONE latches the result.
module tt_um_serial_add_ctrl
  import tt_um_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   uo_out_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               c_r;
  logic               carry_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;
  logic               start_prev_r;
  logic               load_a_s;
  logic               load_b_s;
  logic               start_s;
  logic               start_edge_s;
  logic               last_bit_s;
  logic               sum_s;
  logic               cout_s;
  logic [7:0]         uio_out_s;
  logic               unused_s;

  assign load_a_s     = uio_in[UIO_LOAD_A];
  assign load_b_s     = uio_in[UIO_LOAD_B];
  assign start_s      = uio_in[UIO_START];
  assign start_edge_s = start_s & ~start_prev_r;
  assign last_bit_s   = (cnt_r == LAST_CNT);
  assign unused_s     = ^uio_in[7:3];

  fa_cell u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (c_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_edge_s) state_nxt_s = RUN;
        else              state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_bit_s) state_nxt_s = DONE;
        else            state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (ena) begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end else begin
      state_r <= state_r;
    end
  end

  // Operand, serial datapath and result registers.
  // Operands rotate rather than shift so they are intact after WIDTH steps
  // and a later start without reloading recomputes the same sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r          <= '0;
      b_r          <= '0;
      res_r        <= '0;
      uo_out_r     <= '0;
      cnt_r        <= '0;
      c_r          <= 1'b0;
      carry_r      <= 1'b0;
      ovf_r        <= 1'b0;
      start_prev_r <= 1'b0;
    end else if (ena) begin
      start_prev_r <= start_s;
      case (state_r)
        IDLE: begin
          if (start_edge_s) begin
            c_r   <= 1'b0;
            cnt_r <= '0;
            res_r <= '0;
          end else begin
            if (load_a_s) a_r <= ui_in[WIDTH-1:0];
            if (load_b_s) b_r <= ui_in[WIDTH-1:0];
          end
        end
        RUN: begin
          a_r   <= {a_r[0], a_r[WIDTH-1:1]};
          b_r   <= {b_r[0], b_r[WIDTH-1:1]};
          c_r   <= cout_s;
          res_r <= {sum_s, res_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            uo_out_r <= {sum_s, res_r[WIDTH-1:1]};
            carry_r  <= cout_s;
            ovf_r    <= c_r ^ cout_s;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Pack status flags onto the bidirectional pins.
  always_comb begin
    uio_out_s               = 8'h00;
    uio_out_s[UIO_BUSY]     = busy_r;
    uio_out_s[UIO_DONE]     = done_r;
    uio_out_s[UIO_CARRY]    = carry_r;
    uio_out_s[UIO_OVERFLOW] = ovf_r;
  end

  assign uo_out  = uo_out_r;
  assign uio_out = uio_out_s;
  assign uio_oe  = UIO_OE_VAL;

endmodule
